// File: rtl/lcd_frame_fetch_ctl.sv
// ----------------------------------------------------------------------------
// lcd_frame_fetch_ctl
//
// Write-side scheduler for the LCD pixel FIFO. Walks the frame buffer
// linearly from FRAME_BASE_ADDR and issues one burst read request at a time
// to the AXI read engine. A request goes out only while the FIFO has room for
// a full burst. Each frame restarts on the LCD frame_sync pulse.
//
// A burst is never abandoned once it has been requested. A frame_sync or an
// enable drop that arrives while a burst is in flight is acted on only after
// that burst has completed.
//
// Ports
//   i_fifo_wr_clk   sole clock (FIFO write-clock domain)
//   i_rst           synchronous reset, active-high
//   i_enable        fetch enable, level
//   i_frame_sync    one-cycle pulse, start of vertical blanking
//   i_fifo_wr_cnt   FIFO fill level
//   i_fifo_full     FIFO full flag
//   o_fifo_flush    one-cycle FIFO reset pulse
//   o_rd_req        burst request, held until i_rd_ack
//   o_rd_addr       burst start byte address, stable while o_rd_req
//   o_rd_len        burst beats minus 1, stable while o_rd_req
//   i_rd_ack        read master accepted the request
//   i_rd_done       one-cycle pulse, last beat of the burst written to FIFO
//   o_frame_done    one-cycle pulse, last burst of the frame completed
//   o_busy          high while loading, checking, requesting or transferring
//   o_sync_err      sticky: frame_sync arrived before the frame was fetched
// ----------------------------------------------------------------------------
module lcd_frame_fetch_ctl #(
   parameter logic [31:0] FRAME_BASE_ADDR       = 32'h1000_0000,
   parameter int unsigned H_PIXELS              = 480,
   parameter int unsigned V_LINES               = 272,
   parameter int unsigned BYTES_PER_PIXEL       = 4,
   parameter int unsigned BURST_LEN             = 16,
   parameter int unsigned FIFO_ALMOSTFULL_DEPTH = 960
) (
   input  logic        i_fifo_wr_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_frame_sync,
   input  logic [9:0]  i_fifo_wr_cnt,
   input  logic        i_fifo_full,
   output logic        o_fifo_flush,
   output logic        o_rd_req,
   output logic [31:0] o_rd_addr,
   output logic [7:0]  o_rd_len,
   input  logic        i_rd_ack,
   input  logic        i_rd_done,
   output logic        o_frame_done,
   output logic        o_busy,
   output logic        o_sync_err
);

   localparam logic [23:0] FRAME_BEATS = 24'(H_PIXELS * V_LINES);
   localparam logic [23:0] BURST_BEATS = 24'(BURST_LEN);

   typedef enum logic [2:0] {
      StIdle,
      StWaitSync,
      StLoad,
      StCheck,
      StReq,
      StXfer
   } t_state;

   t_state      r_state;
   logic [31:0] r_rd_addr;
   logic [7:0]  r_rd_len;
   logic [23:0] r_beats_left;
   logic        r_sync_pend;
   logic        r_first;
   logic        r_rd_req;
   logic        r_fifo_flush;
   logic        r_frame_done;
   logic        r_busy;
   logic        r_sync_err;

   logic [10:0] w_space_sum;
   logic        w_space_ok;
   logic [8:0]  w_burst_beats;
   logic [8:0]  w_xfer_beats;
   logic [31:0] w_xfer_bytes;
   logic [23:0] w_beats_after;

   // 11-bit sum so a nearly full FIFO plus a long burst cannot wrap.
   assign w_space_sum = {1'b0, i_fifo_wr_cnt} + 11'(BURST_LEN);
   assign w_space_ok  = (w_space_sum <= 11'(FIFO_ALMOSTFULL_DEPTH)) && !i_fifo_full;

   // The last burst of a frame is shortened to whatever beats remain.
   assign w_burst_beats = (r_beats_left < BURST_BEATS) ? r_beats_left[8:0] : 9'(BURST_LEN);

   assign w_xfer_beats  = {1'b0, r_rd_len} + 9'd1;
   assign w_xfer_bytes  = 32'(w_xfer_beats) * BYTES_PER_PIXEL;
   assign w_beats_after = r_beats_left - 24'(w_xfer_beats);

   always_ff @(posedge i_fifo_wr_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_rd_addr    <= FRAME_BASE_ADDR;
         r_rd_len     <= 8'd0;
         r_beats_left <= 24'd0;
         r_sync_pend  <= 1'b0;
         r_first      <= 1'b1;
         r_rd_req     <= 1'b0;
         r_fifo_flush <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_fifo_flush <= 1'b0;
         r_frame_done <= 1'b0;

         // A frame_sync during a burst is remembered and serviced in StCheck.
         if (i_frame_sync && ((r_state == StReq) || (r_state == StXfer))) begin
            r_sync_pend <= 1'b1;
         end

         case (r_state)
            StIdle: begin
               r_busy <= 1'b0;
               if (i_enable) begin
                  r_state <= StWaitSync;
               end
            end

            StWaitSync: begin
               if (!i_enable) begin
                  r_state <= StIdle;
               end else if (i_frame_sync) begin
                  // Flush lands in the StLoad cycle; only the very first load flushes here.
                  r_fifo_flush <= r_first;
                  r_busy       <= 1'b1;
                  r_state      <= StLoad;
               end
            end

            StLoad: begin
               r_rd_addr    <= FRAME_BASE_ADDR;
               r_beats_left <= FRAME_BEATS;
               r_sync_pend  <= 1'b0;
               r_first      <= 1'b0;
               r_state      <= StCheck;
            end

            StCheck: begin
               if (!i_enable) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else if (i_frame_sync || r_sync_pend) begin
                  // Sync with pixels still owed: the FIFO holds a partial frame, so
                  // drop it and record the error. A finished frame reloads quietly.
                  if (r_beats_left != 24'd0) begin
                     r_sync_err   <= 1'b1;
                     r_fifo_flush <= 1'b1;
                  end
                  r_state <= StLoad;
               end else if ((r_beats_left != 24'd0) && w_space_ok) begin
                  r_rd_len <= 8'(w_burst_beats - 9'd1);
                  r_rd_req <= 1'b1;
                  r_state  <= StReq;
               end
            end

            StReq: begin
               if (i_rd_ack) begin
                  r_rd_req <= 1'b0;
                  r_state  <= StXfer;
               end
            end

            StXfer: begin
               if (i_rd_done) begin
                  r_rd_addr    <= r_rd_addr + w_xfer_bytes;
                  r_beats_left <= w_beats_after;
                  r_frame_done <= (w_beats_after == 24'd0);
                  r_state      <= StCheck;
               end
            end

            default: begin
               r_rd_req <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= StIdle;
            end
         endcase
      end
   end

   assign o_fifo_flush = r_fifo_flush;
   assign o_rd_req     = r_rd_req;
   assign o_rd_addr    = r_rd_addr;
   assign o_rd_len     = r_rd_len;
   assign o_frame_done = r_frame_done;
   assign o_busy       = r_busy;
   assign o_sync_err   = r_sync_err;

endmodule

// File: doc/lcd_frame_fetch_ctl.md
Name: lcd_frame_fetch_ctl

Overview:
- Write-side scheduler for the LCD pixel FIFO.
- Issues single-outstanding burst read requests to the AXI read master, walking the frame buffer linearly from FRAME_BASE_ADDR.
- Throttles requests on FIFO fill level and restarts each frame on the LCD frame_sync pulse.
- Sits between the LCD timing generator (frame_sync), the pixel FIFO write port (fill count, flush) and the AXI burst read engine (req/ack/done).

Parameters:
FRAME_BASE_ADDR, 32'h1000_0000, byte address of pixel (0,0)
H_PIXELS, 480, pixels per line
V_LINES, 272, lines per frame
BYTES_PER_PIXEL, 4, address increment per beat (one pixel per beat)
BURST_LEN, 16, beats per full burst (1..256)
FIFO_ALMOSTFULL_DEPTH, 960, a burst is issued only if fifo_wr_cnt+BURST_LEN <= this value

Ports:
fifo_wr_clk  in  1  sole clock
rst  in  1  synchronous reset, active-high
enable  in  1  fetch enable, level
frame_sync  in  1  one-cycle pulse, start of vertical blanking
fifo_wr_cnt  in  10  FIFO fill level, write-clock domain
fifo_full  in  1  FIFO full flag
fifo_flush  out  1  one-cycle FIFO reset pulse
rd_req  out  1  burst request, held until rd_ack
rd_addr  out  32  burst start byte address, stable while rd_req
rd_len  out  8  burst beats minus 1, stable while rd_req
rd_ack  in  1  read master accepted request
rd_done  in  1  one-cycle pulse, last beat of burst written to FIFO
frame_done  out  1  one-cycle pulse, last burst of frame completed
busy  out  1  high in any state except IDLE/WAIT_SYNC
sync_err  out  1  sticky; frame_sync arrived before frame fully fetched; cleared only by rst

Behaviour:
- Reset: state=IDLE; all outputs 0; rd_addr=FRAME_BASE_ADDR; beats_left=0; sync_pend=0; first=1.
- FRAME_BEATS = H_PIXELS*V_LINES, held in a 24-bit counter (beats_left).
- Space test: 11-bit sum fifo_wr_cnt+BURST_LEN <= FIFO_ALMOSTFULL_DEPTH, and fifo_full==0.
- IDLE: if enable, go to WAIT_SYNC.
- WAIT_SYNC:
  - If !enable, go to IDLE.
  - On frame_sync, go to LOAD.
- LOAD (1 cycle):
  - rd_addr=FRAME_BASE_ADDR; beats_left=FRAME_BEATS; sync_pend=0.
  - fifo_flush=1 this cycle if first==1 or entered via resync; then first=0.
  - Go to CHECK.
- CHECK:
  - Priority 1: !enable, go to IDLE.
  - Priority 2: frame_sync or sync_pend:
    - If beats_left!=0, set sync_err and perform a flushing resync.
    - Go to LOAD.
  - Priority 3: beats_left==0, wait here (frame fetched).
  - Priority 4: space test true, go to REQ.
    - rd_len = min(BURST_LEN, beats_left) - 1, registered.
- REQ:
  - rd_req=1 with rd_addr/rd_len constant.
  - When rd_ack is sampled high: rd_req drops next cycle; go to XFER.
- XFER, on rd_done:
  - rd_addr += (rd_len+1)*BYTES_PER_PIXEL, 32-bit wrap.
  - beats_left -= rd_len+1.
  - If result is 0, frame_done=1 for one cycle.
  - Go to CHECK.
- Latency: CHECK to rd_req high is 1 cycle; rd_done to next rd_req is at least 2 cycles (XFER->CHECK->REQ).
- No burst is ever abandoned once requested:
  - frame_sync during REQ/XFER sets sync_pend, serviced in CHECK.
  - enable low during REQ/XFER: the burst completes, then the FSM goes to IDLE via CHECK.
- rd_done and frame_sync in the same cycle: the completion is applied; sync_pend is set.
  - If that rd_done finished the frame, no sync_err and no flush (normal reload).
- Normal reload (beats_left==0 at frame_sync): no fifo_flush.
- rd_done outside XFER is ignored. rd_ack outside REQ is ignored.
- Short last burst: when FRAME_BEATS mod BURST_LEN != 0, the final rd_len equals the remainder-1.
- busy=1 in LOAD, CHECK, REQ and XFER.
- rst mid-operation (including REQ/XFER): immediate return to reset values. The read master is reset by the same rst.

Test Plan:
- Reset: hold rst 3 cycles with enable=1 -> rd_req=0, fifo_flush=0, busy=0, sync_err=0, rd_addr=32'h1000_0000.
- Single frame (H=8,V=2,BURST=4, base 0, fifo_wr_cnt=0, ack/done 2 cycles after each step):
  - First frame_sync -> one fifo_flush pulse.
  - 4 requests at addresses 0x00,0x10,0x20,0x30 with rd_len=3.
  - frame_done pulse after the 4th rd_done.
  - No further rd_req until the next frame_sync.
- Short last burst (H=10,V=1,BURST=4) -> rd_len sequence 3,3,1; addresses 0x00,0x10,0x20; frame_done after the third.
- Backpressure: fifo_wr_cnt=957 with BURST=4, almost-full 960 -> no rd_req. Drop to 956 -> rd_req on the next cycle. fifo_full=1 -> no rd_req.
- Resync: frame_sync asserted in XFER after 2 of 4 bursts:
  - The burst completes, then sync_err=1 and a fifo_flush pulse.
  - Next rd_addr=0x00, and 4 full bursts follow.
  - A normal frame_sync after frame_done -> no flush, sync_err unchanged.
- enable drop in REQ (rd_ack 5 cycles later) -> rd_req holds until ack; after rd_done the FSM enters IDLE with busy=0. rst asserted in XFER -> next cycle all outputs at reset values.
